hdpldadapt_tx_async_ssr_serializer: RTL and testbench



---
 rtl/hdpldadapt_sr_pkg.sv | 26 ++
 rtl/hdpldadapt_sr_shift_reg.sv | 68 ++++++
 rtl/hdpldadapt_tx_async_ssr_serializer.sv | 131 +++++++++++++
 tb/tb_hdpldadapt_tx_async_ssr_serializer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/hdpldadapt_sr_pkg.sv
// ---------------------------------------------------------------------------
// hdpldadapt_sr_pkg : state encoding and counter sizing for the SSR serializer/deserializer
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package hdpldadapt_sr_pkg;

  typedef enum logic [2:0] {
    SR_IDLE  = 3'd0,
    SR_LOAD  = 3'd1,
    SR_CAPT  = 3'd2,
    SR_SHIFT = 3'd3,
    SR_GAP   = 3'd4
  } sr_state_e;

  localparam int SR_GAP_CNT_W = 8;

  // Bit counter must index DATA_WIDTH-1 down to 0; keep it at least one bit wide.
  function automatic int sr_bit_cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hdpldadapt_sr_shift_reg.sv
// ---------------------------------------------------------------------------
// hdpldadapt_sr_shift_reg : shadow register, bit counter and registered serial bit
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hdpldadapt_sr_shift_reg #(
  parameter int   DATA_WIDTH       = 3,
  parameter int   CNT_W            = 2,
  parameter logic SHADOW_RESET_VAL = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  capture,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] par_in,
  output logic                  ser_out,
  output logic [CNT_W-1:0]      bit_cnt
);

  logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ser_q, ser_d;
  logic                  next_bit;

  // Shadow stays untouched while shifting; the counter selects the outgoing bit.
  generate
    if (DATA_WIDTH == 1) begin : g_single
      assign next_bit = shadow_q[0];
    end else begin : g_multi
      logic [CNT_W-1:0] cnt_dec;
      assign cnt_dec  = cnt_q - CNT_W'(1);
      assign next_bit = shadow_q[cnt_dec];
    end
  endgenerate

  always_comb begin
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    ser_d    = SHADOW_RESET_VAL;
    if (capture) begin
      shadow_d = par_in;
      cnt_d    = CNT_W'(DATA_WIDTH - 1);
      ser_d    = par_in[DATA_WIDTH-1];
    end else if (shift && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
      ser_d = next_bit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= {DATA_WIDTH{SHADOW_RESET_VAL}};
      cnt_q    <= '0;
      ser_q    <= SHADOW_RESET_VAL;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      ser_q    <= ser_d;
    end
  end

  assign ser_out = ser_q;
  assign bit_cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/hdpldadapt_tx_async_ssr_serializer.sv
// ---------------------------------------------------------------------------
// hdpldadapt_tx_async_ssr_serializer : periodic SSR load, capture and MSB-first framed serial output
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hdpldadapt_tx_async_ssr_serializer
  import hdpldadapt_sr_pkg::*;
#(
  parameter int   DATA_WIDTH       = 3,
  parameter int   GAP_CYCLES       = 2,
  parameter logic SHADOW_RESET_VAL = 1'b1
) (
  input  logic                  tx_clock_async_tx_osc_clk,
  input  logic                  tx_reset_async_tx_osc_clk_rst,
  input  logic                  sr_enable,
  input  logic [DATA_WIDTH-1:0] tx_async_fabric_hssi_ssr_reserved,
  output logic                  tx_async_fabric_hssi_ssr_load,
  output logic                  sr_data_out,
  output logic                  sr_frame_start,
  output logic                  sr_frame_done,
  output logic                  sr_busy
);

  localparam int CNT_W = sr_bit_cnt_w(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [SR_GAP_CNT_W-1:0] GAP_LAST =
    SR_GAP_CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  sr_state_e               state_q, state_d;
  logic [SR_GAP_CNT_W-1:0] gap_q, gap_d;
  logic                    load_q, load_d;
  logic                    start_q, start_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic                    sr_capture, sr_shift, sr_last;
  logic [CNT_W-1:0]        bit_cnt;

  assign sr_last = (bit_cnt == '0);

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    load_d     = 1'b0;
    start_d    = 1'b0;
    done_d     = 1'b0;
    sr_capture = 1'b0;
    sr_shift   = 1'b0;
    case (state_q)
      SR_IDLE: begin
        if (sr_enable) begin
          state_d = SR_LOAD;
          load_d  = 1'b1;
        end
      end
      SR_LOAD: state_d = SR_CAPT;
      SR_CAPT: begin
        state_d    = SR_SHIFT;
        sr_capture = 1'b1;
        start_d    = 1'b1;
        done_d     = (DATA_WIDTH == 1);
      end
      SR_SHIFT: begin
        if (!sr_last) begin
          sr_shift = 1'b1;
          done_d   = (bit_cnt == CNT_ONE);
        end else if (GAP_CYCLES != 0) begin
          state_d = SR_GAP;
          gap_d   = GAP_LAST;
        end else if (sr_enable) begin
          state_d = SR_LOAD;
          load_d  = 1'b1;
        end else begin
          state_d = SR_IDLE;
        end
      end
      SR_GAP: begin
        if (gap_q != '0) begin
          gap_d = gap_q - SR_GAP_CNT_W'(1);
        end else if (sr_enable) begin
          state_d = SR_LOAD;
          load_d  = 1'b1;
        end else begin
          state_d = SR_IDLE;
        end
      end
      default: state_d = SR_IDLE;
    endcase
    busy_d = (state_d != SR_IDLE);
  end

  always_ff @(posedge tx_clock_async_tx_osc_clk or posedge tx_reset_async_tx_osc_clk_rst) begin
    if (tx_reset_async_tx_osc_clk_rst) begin
      state_q <= SR_IDLE;
      gap_q   <= '0;
      load_q  <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      load_q  <= load_d;
      start_q <= start_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  hdpldadapt_sr_shift_reg #(
    .DATA_WIDTH       (DATA_WIDTH),
    .CNT_W            (CNT_W),
    .SHADOW_RESET_VAL (SHADOW_RESET_VAL)
  ) u_shift_reg (
    .clk     (tx_clock_async_tx_osc_clk),
    .rst     (tx_reset_async_tx_osc_clk_rst),
    .capture (sr_capture),
    .shift   (sr_shift),
    .par_in  (tx_async_fabric_hssi_ssr_reserved),
    .ser_out (sr_data_out),
    .bit_cnt (bit_cnt)
  );

  assign tx_async_fabric_hssi_ssr_load = load_q;
  assign sr_frame_start                = start_q;
  assign sr_frame_done                 = done_q;
  assign sr_busy                       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_hdpldadapt_tx_async_ssr_serializer.sv
// ---------------------------------------------------------------------------
// tb_hdpldadapt_tx_async_ssr_serializer : directed table, reset corners and randomized model comparison
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hdpldadapt_tx_async_ssr_serializer;

  localparam int TB_W = 3;
  localparam int TB_G = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [2:0] din = 3'b101;
  logic       load, dout, start, done, busy;

  logic       en1  = 1'b0;
  logic [0:0] din1 = 1'b0;
  logic       load1, dout1, start1, done1, busy1;

  int n_err    = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  hdpldadapt_tx_async_ssr_serializer #(
    .DATA_WIDTH (TB_W), .GAP_CYCLES (TB_G), .SHADOW_RESET_VAL (1'b1)
  ) dut (
    .tx_clock_async_tx_osc_clk         (clk),
    .tx_reset_async_tx_osc_clk_rst     (rst),
    .sr_enable                         (en),
    .tx_async_fabric_hssi_ssr_reserved (din),
    .tx_async_fabric_hssi_ssr_load     (load),
    .sr_data_out                       (dout),
    .sr_frame_start                    (start),
    .sr_frame_done                     (done),
    .sr_busy                           (busy)
  );

  hdpldadapt_tx_async_ssr_serializer #(
    .DATA_WIDTH (1), .GAP_CYCLES (0), .SHADOW_RESET_VAL (1'b1)
  ) dut1 (
    .tx_clock_async_tx_osc_clk         (clk),
    .tx_reset_async_tx_osc_clk_rst     (rst),
    .sr_enable                         (en1),
    .tx_async_fabric_hssi_ssr_reserved (din1),
    .tx_async_fabric_hssi_ssr_load     (load1),
    .sr_data_out                       (dout1),
    .sr_frame_start                    (start1),
    .sr_frame_done                     (done1),
    .sr_busy                           (busy1)
  );

  // Output vector order: {load, data, start, done, busy}
  typedef struct {
    logic       en;
    logic [2:0] din;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic e, input logic [2:0] d, input logic [4:0] x);
    vec_t v;
    v.en  = e;
    v.din = d;
    v.exp = x;
    return v;
  endfunction

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got {load,data,start,done,busy}=%b expected %b", name, act, exp);
    end
  endtask

  // Frame schedule model: a load at edge L delivers the word present before edge L+2
  // on edges L+2 .. L+1+W; the next enable decision is at edge L+2+W+G.
  int         m_n;
  bit         m_idle;
  int         m_l;
  int         m_d;
  logic [2:0] m_word;

  task automatic model_reset();
    m_n    = 0;
    m_idle = 1'b1;
    m_l    = -100;
    m_d    = -100;
    m_word = 3'b111;
  endtask

  task automatic model_edge(input logic e, input logic [2:0] d);
    m_n++;
    if (m_idle) begin
      if (e) begin
        m_idle = 1'b0;
        m_l    = m_n;
        m_d    = m_n + 2 + TB_W + TB_G;
      end
    end else if (m_n == m_d) begin
      if (e) begin
        m_l = m_n;
        m_d = m_n + 2 + TB_W + TB_G;
      end else begin
        m_idle = 1'b1;
      end
    end
    if (m_n == m_l + 2) m_word = d;
  endtask

  function automatic logic [4:0] model_exp();
    int   k;
    logic b, s, f;
    k = m_n - m_l - 2;
    b = 1'b1;
    s = 1'b0;
    f = 1'b0;
    if (k >= 0 && k < TB_W) begin
      b = m_word[TB_W-1-k];
      s = (k == 0);
      f = (k == TB_W - 1);
    end
    return {m_n == m_l, b, s, f, !m_idle};
  endfunction

  // Drive at the falling edge, clock once, return at the next falling edge.
  task automatic cycle(input logic e, input logic [2:0] d);
    en  = e;
    din = d;
    @(posedge clk);
    if (!rst) model_edge(e, d);
    @(negedge clk);
  endtask

  initial begin
    logic       e_r;
    logic [2:0] d_r;
    logic [0:0] prev_din1;

    vecs[0]  = mk(1'b0, 3'b101, 5'b01000);
    vecs[1]  = mk(1'b0, 3'b101, 5'b01000);
    vecs[2]  = mk(1'b0, 3'b101, 5'b01000);
    vecs[3]  = mk(1'b1, 3'b101, 5'b11001);
    vecs[4]  = mk(1'b1, 3'b101, 5'b01001);
    vecs[5]  = mk(1'b1, 3'b101, 5'b01101);
    vecs[6]  = mk(1'b1, 3'b010, 5'b00001);
    vecs[7]  = mk(1'b1, 3'b010, 5'b01011);
    vecs[8]  = mk(1'b1, 3'b010, 5'b01001);
    vecs[9]  = mk(1'b1, 3'b010, 5'b01001);
    vecs[10] = mk(1'b1, 3'b010, 5'b11001);
    vecs[11] = mk(1'b1, 3'b010, 5'b01001);
    vecs[12] = mk(1'b1, 3'b010, 5'b00101);
    vecs[13] = mk(1'b0, 3'b101, 5'b01001);
    vecs[14] = mk(1'b0, 3'b101, 5'b00011);
    vecs[15] = mk(1'b0, 3'b101, 5'b01001);
    vecs[16] = mk(1'b0, 3'b101, 5'b01001);
    vecs[17] = mk(1'b0, 3'b101, 5'b01000);
    vecs[18] = mk(1'b0, 3'b101, 5'b01000);
    vecs[19] = mk(1'b0, 3'b101, 5'b01000);

    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_state", {load, dout, start, done, busy}, 5'b01000);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      cycle(vecs[i].en, vecs[i].din);
      chk($sformatf("table[%0d]", i), {load, dout, start, done, busy}, vecs[i].exp);
    end

    // Reset in the middle of a frame, then restart with enable held high.
    cycle(1'b1, 3'b101);
    cycle(1'b1, 3'b101);
    cycle(1'b1, 3'b101);
    cycle(1'b1, 3'b101);
    chk("pre_reset_midshift", {load, dout, start, done, busy}, 5'b00001);
    rst = 1'b1;
    #1;
    chk("async_reset_midshift", {load, dout, start, done, busy}, 5'b01000);
    model_reset();
    @(negedge clk);
    chk("reset_held_enable_high", {load, dout, start, done, busy}, 5'b01000);
    rst = 1'b0;
    cycle(1'b1, 3'b011);
    chk("load_after_release", {load, dout, start, done, busy}, 5'b11001);
    chk("model_after_release", {load, dout, start, done, busy}, model_exp());

    e_r = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(7) == 0) e_r = ~e_r;
      d_r = 3'($urandom);
      cycle(e_r, d_r);
      chk($sformatf("random[%0d]", i), {load, dout, start, done, busy}, model_exp());
    end

    // Single-bit word with no gap: load every third cycle, start and done together.
    cycle(1'b0, 3'b000);
    repeat (12) cycle(1'b0, 3'b000);
    en1       = 1'b1;
    prev_din1 = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      din1 = 1'($urandom);
      @(posedge clk);
      if (i % 3 == 0) prev_din1 = din1;
      @(negedge clk);
      chk($sformatf("w1g0[%0d]", i), {load1, dout1, start1, done1, busy1},
          {(i % 3 == 1), (i % 3 == 0) ? prev_din1[0] : 1'b1, (i % 3 == 0), (i % 3 == 0), 1'b1});
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
